// File: rtl/clk_div_pkg.sv
// clk_div_pkg -- shared constants and helpers for the clk_div_gen slice.
//   DEF_CNT_W     default divide-ratio / counter width
//   DEF_RESET_DIV default ratio every channel loads at reset
//   MIN_DIV       smallest legal divide ratio
//   ch_width()    width of a channel index for a given channel count
package clk_div_pkg;

  localparam int DEF_CNT_W     = 16;
  localparam int DEF_RESET_DIV = 4;
  localparam int MIN_DIV       = 2;

  // A single-channel build still needs a 1-bit channel select port.
  function automatic int ch_width(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch -- one divider channel: counter, active ratio, optional shadow
// ratio, and the registered tick / clk_out outputs.
//
// Build option: define CLK_DIV_SHADOW_EN to stage new ratios in a shadow
// register that takes effect on the next period wrap (phase-continuous).
// Without it a new ratio takes effect at once and restarts the period.
//
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   en         count enable
//   sync       restart the period at cnt=0 on the next edge
//   ld, ld_div validated ratio write for this channel
//   tick       one-cycle pulse per period
//   clk_out    divided square wave, high floor(D/2), low ceil(D/2)
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int RESET_DIV = DEF_RESET_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_div,
  output logic             tick,
  output logic             clk_out
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(RESET_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wrap;
  logic             high;

  // ">=" rather than "==" keeps cnt inside 0..D-1 even if the ratio were
  // ever lowered under a running counter; it also means D = 2^CNT_W-1
  // wraps at D-1 and cnt+1 can never overflow.
  assign wrap    = (cnt >= div - ONE);
  assign cnt_nxt = wrap ? '0 : cnt + ONE;
  assign high    = (cnt < (div >> 1));

`ifdef CLK_DIV_SHADOW_EN

  logic [CNT_W-1:0] shadow;
  logic             pend;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would chain cnt -> tick within one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      div     <= DIV_RST;
      shadow  <= DIV_RST;
      pend    <= 1'b0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else if (sync) begin
      cnt  <= '0;
      tick <= 1'b0;
      // A sync is a period boundary, so a staged ratio lands here. A write
      // arriving on the same edge is the newest value and wins.
      if (ld) begin
        div  <= ld_div;
        pend <= 1'b0;
      end else if (pend) begin
        div  <= shadow;
        pend <= 1'b0;
      end
    end else begin
      tick <= en && wrap;
      if (en) begin
        cnt     <= cnt_nxt;
        clk_out <= high;
      end
      if (en && wrap) begin
        if (ld) begin
          div  <= ld_div;
          pend <= 1'b0;
        end else if (pend) begin
          div  <= shadow;
          pend <= 1'b0;
        end
      end else if (ld) begin
        // A second write before the wrap simply overwrites the staged value.
        shadow <= ld_div;
        pend   <= 1'b1;
      end
    end
  end

`else

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      div     <= DIV_RST;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else if (sync) begin
      cnt  <= '0;
      tick <= 1'b0;
      // Sync already restarts the period, so a coincident write can land
      // without disturbing the realignment.
      if (ld) div <= ld_div;
    end else if (ld) begin
      div  <= ld_div;
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= en && wrap;
      if (en) begin
        cnt     <= cnt_nxt;
        clk_out <= high;
      end
    end
  end

`endif

endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen -- bank of NUM_CH programmable clock-enable dividers.
//
// Build option: CLK_DIV_SHADOW_EN selects phase-continuous ratio updates
// (see clk_div_ch); undefined gives immediate update with period restart.
//
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   cfg_valid   ratio write request
//   cfg_ready   write accepted when cfg_valid && cfg_ready; low for one
//               cycle after each accepted write and during reset
//   cfg_ch      target channel
//   cfg_div     requested divide ratio (>= 2)
//   cfg_err     one-cycle pulse after an accepted but illegal write
//   en          per-channel count enable
//   sync        realign all channels to cnt=0
//   tick        per-channel one-cycle pulse per period
//   clk_out     per-channel divided square wave
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int CNT_W     = DEF_CNT_W,
  parameter  int RESET_DIV = DEF_RESET_DIV,
  localparam int CH_W      = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  logic accept;
  logic cfg_ok;

  assign accept = cfg_valid && cfg_ready;
  // The channel field can encode indices beyond NUM_CH when NUM_CH is not a
  // power of two; those writes are rejected like too-small ratios.
  assign cfg_ok = (cfg_div >= CNT_W'(MIN_DIV)) && (32'(cfg_ch) < NUM_CH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_ready <= !accept;
      cfg_err   <= accept && !cfg_ok;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic ch_ld;

    assign ch_ld = accept && cfg_ok && (cfg_ch == CH_W'(g));

    clk_div_ch #(
      .CNT_W     (CNT_W),
      .RESET_DIV (RESET_DIV)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[g]),
      .sync    (sync),
      .ld      (ch_ld),
      .ld_div  (cfg_div),
      .tick    (tick[g]),
      .clk_out (clk_out[g])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen -- directed bench for clk_div_gen with an event/level
// scoreboard. Stimulus pushes expected (cycle, source, value) entries; the
// monitor matches tick / cfg_err pulses and level samples on each falling
// edge. Cycle k = value of the posedge counter, i.e. outputs after edge k.
module tb_clk_div_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;
  localparam int CH_W3  = 3;

  // Scoreboard sources: 0..3 main ticks (events), then events, then levels.
  localparam int S_ERR   = 4;
  localparam int S_ERR3  = 5;
  localparam int S_TICK3 = 6;
  localparam int L_CLK   = 8;
  localparam int L_TICK  = 9;
  localparam int L_RDY   = 10;
  localparam int L_ERR   = 11;
  localparam int L_RDY3  = 12;

  typedef struct {
    int         cyc;
    int         src;
    logic [7:0] val;
    logic [7:0] mask;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic              cfg_err;
  logic [NUM_CH-1:0] en = '0;
  logic              sync = 1'b0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] clk_out;

  logic              cfg_valid3 = 1'b0;
  logic              cfg_ready3;
  logic [CH_W3-1:0]  cfg_ch3 = '0;
  logic [CNT_W-1:0]  cfg_div3 = '0;
  logic              cfg_err3;
  logic [4:0]        en3 = '0;
  logic              sync3 = 1'b0;
  logic [4:0]        tick3;
  logic [4:0]        clk_out3;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   ev_on = 1'b0;

  clk_div_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RESET_DIV(4)) u_dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_err(cfg_err), .en(en),
    .sync(sync), .tick(tick), .clk_out(clk_out)
  );

  // Five channels so an out-of-range index (5) is encodable.
  clk_div_gen #(.NUM_CH(5), .CNT_W(CNT_W), .RESET_DIV(4)) u_dut5 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
    .cfg_ch(cfg_ch3), .cfg_div(cfg_div3), .cfg_err(cfg_err3), .en(en3),
    .sync(sync3), .tick(tick3), .clk_out(clk_out3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string src_name(input int s);
    if (s < NUM_CH) return $sformatf("tick%0d", s);
    case (s)
      S_ERR:   return "cfg_err";
      S_ERR3:  return "cfg_err_dut5";
      S_TICK3: return "tick_dut5";
      L_CLK:   return "clk_out";
      L_TICK:  return "tick_vec";
      L_RDY:   return "cfg_ready";
      L_ERR:   return "cfg_err_lvl";
      L_RDY3:  return "cfg_ready_dut5";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [7:0] level_of(input int s);
    case (s)
      L_CLK:   return 8'(clk_out);
      L_TICK:  return 8'(tick);
      L_RDY:   return 8'(cfg_ready);
      L_ERR:   return 8'(cfg_err);
      L_RDY3:  return 8'(cfg_ready3);
      default: return 8'h00;
    endcase
  endfunction

  function automatic void push(input int c, input int s, input logic [7:0] v,
                               input logic [7:0] m);
    exp_t e;
    e.cyc = c; e.src = s; e.val = v; e.mask = m;
    sb.push_back(e);
  endfunction

  function automatic void push_ticks(input int ch, input int first,
                                     input int step, input int last);
    for (int t = first; t <= last; t += step) push(t, ch, 8'h01, 8'h01);
  endfunction

  function automatic bit p4(input int k);
    return (k % 4 == 1) || (k % 4 == 2);
  endfunction

  task automatic match_event(input int s);
    int idx;
    idx = -1;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc == cyc && sb[i].src == s) begin
        idx = i;
        break;
      end
    end
    n_checks++;
    if (idx < 0) begin
      n_errors++;
      $display("FAIL %s: pulse at cycle %0d, expected no pulse", src_name(s), cyc);
    end else begin
      sb.delete(idx);
    end
  endtask

  // Monitor: runs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (ev_on) begin
      for (int ch = 0; ch < NUM_CH; ch++) if (tick[ch]) match_event(ch);
    end
    if (cfg_err) match_event(S_ERR);
    if (cfg_err3) match_event(S_ERR3);
    if (tick3 != '0) match_event(S_TICK3);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        n_checks++;
        if (sb[i].src >= L_CLK) begin
          if (sb[i].cyc != cyc ||
              (level_of(sb[i].src) & sb[i].mask) != (sb[i].val & sb[i].mask)) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %b, expected %b (mask %b)",
                     src_name(sb[i].src), sb[i].cyc, level_of(sb[i].src),
                     sb[i].val, sb[i].mask);
          end
        end else begin
          n_errors++;
          $display("FAIL %s: missing pulse, expected at cycle %0d, got none",
                   src_name(sb[i].src), sb[i].cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic cfg_write(input int ch, input int div);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_div   = CNT_W'(div);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, s, s2, c, r2;
    logic b1, b0, b3;

    // ---- Reset state ----
    @(negedge clk);
    push(2, L_RDY, 8'h00, 8'h01);
    push(2, L_CLK, 8'h00, 8'h0F);
    push(2, L_TICK, 8'h00, 8'h0F);
    push(2, L_ERR, 8'h00, 8'h01);
    wait_until(2);

    // ---- Release, all channels at RESET_DIV=4; ch1 rewritten to 5 ----
    r = cyc;
    rst = 1'b0;
    en  = 4'hF;
    ev_on = 1'b1;
    push(r + 1, L_RDY, 8'h01, 8'h01);
    push(r + 10, L_RDY, 8'h00, 8'h01);
    push(r + 11, L_RDY, 8'h01, 8'h01);
    push_ticks(0, r + 4, 4, r + 40);
    push_ticks(2, r + 4, 4, r + 40);
    push_ticks(3, r + 4, 4, r + 40);
`ifdef CLK_DIV_SHADOW_EN
    push_ticks(1, r + 4, 4, r + 12);
    push_ticks(1, r + 17, 5, r + 40);
`else
    push_ticks(1, r + 4, 4, r + 8);
    push_ticks(1, r + 15, 5, r + 40);
`endif
    for (int k = 1; k <= 30; k++) begin
`ifdef CLK_DIV_SHADOW_EN
      b1 = (k <= 12) ? p4(k) : ((k - 13) % 5 < 2);
`else
      b1 = (k <= 10) ? p4(k) : ((k - 11) % 5 < 2);
`endif
      push(r + k, L_CLK, {4'h0, p4(k), p4(k), b1, p4(k)}, 8'h0F);
    end
    wait_until(r + 9);            // ch1 cnt=1 during this cycle
    cfg_write(1, 5);

    // ---- Illegal writes (main) and back-to-back handshake (dut5) ----
    push(r + 32, S_ERR, 8'h01, 8'h01);
    push(r + 35, S_ERR, 8'h01, 8'h01);
    push(r + 32, L_RDY, 8'h00, 8'h01);
    push(r + 33, L_RDY, 8'h01, 8'h01);
    push(r + 35, L_RDY, 8'h00, 8'h01);
    push(r + 36, L_RDY, 8'h01, 8'h01);
    push(r + 32, S_ERR3, 8'h01, 8'h01);
    push(r + 31, L_RDY3, 8'h01, 8'h01);
    push(r + 32, L_RDY3, 8'h00, 8'h01);
    push(r + 33, L_RDY3, 8'h01, 8'h01);
    push(r + 34, L_RDY3, 8'h00, 8'h01);
    push(r + 35, L_RDY3, 8'h01, 8'h01);
    wait_until(r + 31);
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd1;
    cfg_valid3 = 1'b1; cfg_ch3 = 3'd5; cfg_div3 = 8'd9;
    wait_until(r + 32);
    cfg_valid = 1'b0;
    cfg_ch3 = 3'd4;
    wait_until(r + 34);
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0;
    cfg_valid3 = 1'b0;
    wait_until(r + 35);
    cfg_valid = 1'b0;

    // ---- ch0 D=3, ch3 D=7, then sync with en low ----
    wait_until(r + 41);
    ev_on = 1'b0;
    cfg_write(0, 3);
    wait_until(r + 43);
    cfg_write(3, 7);
    wait_until(r + 55);
    sync = 1'b1;
    en   = 4'h0;
    wait_until(r + 56);
    s = cyc;
    sync = 1'b0;
    en   = 4'hF;
    ev_on = 1'b1;
    push_ticks(0, s + 3, 3, s + 28);
    push_ticks(1, s + 5, 5, s + 28);
    push_ticks(2, s + 4, 4, s + 28);
    push_ticks(3, s + 7, 7, s + 28);

    // ---- Maximum ratio 2^CNT_W-1 on ch2 ----
    wait_until(s + 29);
    ev_on = 1'b0;
    cfg_write(2, 255);
    wait_until(s + 32);
    sync = 1'b1;
    wait_until(s + 33);
    s2 = cyc;
    sync = 1'b0;
    ev_on = 1'b1;
    push_ticks(0, s2 + 3, 3, s2 + 520);
    push_ticks(1, s2 + 5, 5, s2 + 520);
    push_ticks(2, s2 + 255, 255, s2 + 520);
    push_ticks(3, s2 + 7, 7, s2 + 520);
    for (int k = 1; k <= 8; k++) begin
      b0 = ((k - 1) % 3 < 1);
      b3 = ((k - 1) % 7 < 3);
      push(s2 + k, L_CLK, {4'h0, b3, 2'b00, b0}, 8'h09);
    end
    push(s2 + 127, L_CLK, 8'h04, 8'h04);
    push(s2 + 128, L_CLK, 8'h00, 8'h04);
    push(s2 + 255, L_CLK, 8'h00, 8'h04);
    push(s2 + 256, L_CLK, 8'h04, 8'h04);

    // ---- Pending write on ch1, en toggling, async reset mid-cycle ----
    wait_until(s2 + 521);
    ev_on = 1'b0;
    en = 4'b1101;
    cfg_write(1, 9);
    for (int i = 0; i < 5; i++) begin
      en = 4'($urandom) & 4'b1101;
      @(negedge clk);
    end
    c = cyc + 1;
    push(c, L_CLK, 8'h00, 8'h0F);
    push(c, L_TICK, 8'h00, 8'h0F);
    push(c, L_RDY, 8'h00, 8'h01);
    push(c, L_ERR, 8'h00, 8'h01);
    @(posedge clk);
    #2 rst = 1'b1;
    wait_until(c + 1);
    r2 = cyc;
    rst = 1'b0;
    en  = 4'hF;
    ev_on = 1'b1;
    push(r2 + 1, L_RDY, 8'h01, 8'h01);
    for (int ch = 0; ch < NUM_CH; ch++) push_ticks(ch, r2 + 4, 4, r2 + 24);
    for (int k = 1; k <= 8; k++)
      push(r2 + k, L_CLK, {4'h0, {4{p4(k)}}}, 8'h0F);

    wait_until(r2 + 26);
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
